// File: rtl/mem_dump_pkg.sv
// Shared constants, state encoding and small helpers for the memory dump engine.
package mem_dump_pkg;

  localparam int unsigned NB_DATA_DEF    = 32;
  localparam int unsigned NB_ADDR_DEF    = 7;
  localparam int unsigned NB_BYTE_DEF    = 8;
  localparam int unsigned BYTES_PER_WORD = NB_DATA_DEF / NB_BYTE_DEF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SET_ADDR  = 3'd1,
    ST_WAIT_READ = 3'd2,
    ST_CAPTURE   = 3'd3,
    ST_SEND      = 3'd4,
    ST_CHKSUM    = 3'd5,
    ST_DONE      = 3'd6
  } dump_state_e;

  function automatic int unsigned bytes_per_word(input int unsigned nb_data,
                                                 input int unsigned nb_byte);
    return nb_data / nb_byte;
  endfunction

  // Index counters need at least one bit even for a single-byte word.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_dump_unit_if.sv
// Memory-side and UART-side signals of the dump engine, grouped with master/slave views.
interface mem_dump_unit_if
  import mem_dump_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_ADDR = NB_ADDR_DEF,
  parameter int unsigned NB_BYTE = NB_BYTE_DEF
);

  logic               start_i;
  logic [NB_DATA-1:0] data_read_i;
  logic               tx_ready_i;
  logic [NB_ADDR-1:0] addr_mem_debug_o;
  logic               select_debug_o;
  logic [NB_BYTE-1:0] tx_byte_o;
  logic               tx_valid_o;
  logic               busy_o;
  logic               done_o;

  // The dump engine drives the memory address and the transmit stream.
  modport master (
    input  start_i, data_read_i, tx_ready_i,
    output addr_mem_debug_o, select_debug_o, tx_byte_o, tx_valid_o, busy_o, done_o
  );

  modport slave (
    output start_i, data_read_i, tx_ready_i,
    input  addr_mem_debug_o, select_debug_o, tx_byte_o, tx_valid_o, busy_o, done_o
  );

endinterface

// File: rtl/mem_dump_unit_word_serializer.sv
// Holds one memory word and presents it MSB byte first, advancing one byte per handshake.
module word_serializer
  import mem_dump_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_BYTE = NB_BYTE_DEF
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [NB_DATA-1:0] word_i,
  input  logic               shift_i,
  output logic [NB_BYTE-1:0] byte_o,
  output logic               last_o
);

  localparam int unsigned BPW   = bytes_per_word(NB_DATA, NB_BYTE);
  localparam int unsigned IDX_W = idx_width(BPW);

  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               last_q, last_d;

  // Load wins over shift; shifted-out bytes are replaced by zeros.
  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load_i) begin
      shreg_d = word_i;
      idx_d   = '0;
    end else if (shift_i) begin
      shreg_d = shreg_q << NB_BYTE;
      idx_d   = idx_q + IDX_W'(1);
    end
    last_d = (idx_d == IDX_W'(BPW - 1));
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      shreg_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign byte_o = shreg_q[NB_DATA-1 -: NB_BYTE];
  assign last_o = last_q;

endmodule

// File: rtl/mem_dump_unit.sv
// Halted-pipeline memory dump: walks every data-memory word and streams its bytes to the UART.
// Define MEM_DUMP_CHECKSUM_EN to append an XOR checksum byte after the last data byte.
module mem_dump_unit
  import mem_dump_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_ADDR = NB_ADDR_DEF,
  parameter int unsigned NB_BYTE = NB_BYTE_DEF
) (
  input  logic            clock_i,
  input  logic            reset_i,
  mem_dump_unit_if.master bus
);

  localparam logic [NB_ADDR-1:0] ADDR_LAST = {NB_ADDR{1'b1}};

  dump_state_e        state_q, state_d;
  logic [NB_ADDR-1:0] cnt_q, cnt_d;
  logic               select_q, busy_q, valid_q, done_q;

  logic               ser_load, ser_shift, ser_last;
  logic [NB_DATA-1:0] ser_word;
  logic [NB_BYTE-1:0] ser_byte;
  logic               handshake;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] chk_q, chk_d;
`endif

  assign handshake = valid_q & bus.tx_ready_i;

  // Next-state, address counter and serializer control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    ser_word  = bus.data_read_i;
`ifdef MEM_DUMP_CHECKSUM_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_d = ST_SET_ADDR;
          cnt_d   = '0;
`ifdef MEM_DUMP_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      ST_SET_ADDR:  state_d = ST_WAIT_READ;
      ST_WAIT_READ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        ser_load = 1'b1;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (handshake) begin
          ser_shift = 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
          chk_d     = chk_q ^ ser_byte;
`endif
          if (ser_last) begin
            if (cnt_q == ADDR_LAST) begin
`ifdef MEM_DUMP_CHECKSUM_EN
              // Reuse the serializer to present the checksum as a normal byte.
              state_d  = ST_CHKSUM;
              ser_load = 1'b1;
              ser_word = NB_DATA'(chk_q ^ ser_byte) << (NB_DATA - NB_BYTE);
`else
              state_d  = ST_DONE;
              cnt_d    = '0;
`endif
            end else begin
              cnt_d   = cnt_q + NB_ADDR'(1);
              state_d = ST_SET_ADDR;
            end
          end
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      ST_CHKSUM: begin
        if (handshake) begin
          ser_shift = 1'b1;
          state_d   = ST_DONE;
          cnt_d     = '0;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status outputs registered from the next state so they line up with the state register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      select_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      select_q <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      busy_q   <= (state_d != ST_IDLE);
      valid_q  <= (state_d == ST_SEND) || (state_d == ST_CHKSUM);
      done_q   <= (state_d == ST_DONE);
    end
  end

`ifdef MEM_DUMP_CHECKSUM_EN
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end
`endif

  word_serializer #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_ser (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .load_i  (ser_load),
    .word_i  (ser_word),
    .shift_i (ser_shift),
    .byte_o  (ser_byte),
    .last_o  (ser_last)
  );

  assign bus.addr_mem_debug_o = cnt_q;
  assign bus.select_debug_o   = select_q;
  assign bus.tx_byte_o        = ser_byte;
  assign bus.tx_valid_o       = valid_q;
  assign bus.busy_o           = busy_q;
  assign bus.done_o           = done_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Self-checking bench for mem_dump_unit against a byte-stream model of the memory contents.
module tb_mem_dump_unit;

  localparam int unsigned NB_DATA = 32;
  localparam int unsigned NB_ADDR = 7;
  localparam int unsigned NB_BYTE = 8;
  localparam int unsigned DEPTH   = 128;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_dump_unit_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE)) bus ();

  mem_dump_unit #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_BYTE(NB_BYTE)) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  logic [31:0] mem [DEPTH];
  always @(posedge clk) bus.data_read_i <= mem[bus.addr_mem_debug_o];

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         hs_ev_q[$];
  int         done_cnt, done_at, first_valid_ev, viol;
  bit         timed_out;
  logic [6:0] addr_e1, addr_e8;
  logic       sel_e1;

  // Reference: every word MSB byte first, in address order, optional XOR of all bytes at the end.
  function automatic void build_expected();
    logic [7:0] b, chk;
    exp_q.delete();
    chk = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'((mem[i] >> (24 - 8 * k)) & 32'hFF);
        exp_q.push_back(b);
        chk = chk ^ b;
      end
    end
    if (CHK_EXTRA == 1) exp_q.push_back(chk);
  endfunction

  // Starts a dump (start driven right after edge N) and records everything until shortly after done.
  task automatic run_dump(input bit rand_ready, input int poke_ev);
    int ev, post;
    logic pv, pr;
    logic [7:0] pb;
    got_q.delete(); hs_ev_q.delete();
    done_cnt = 0; done_at = -1; first_valid_ev = -1; viol = 0; timed_out = 0;
    pv = 1'b0; pr = 1'b0; pb = 8'h00; post = 0;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.tx_ready_i = 1'b1;
    ev = 0;
    while (post < 4) begin
      @(posedge clk); ev++; #1;
      bus.start_i    = (ev == poke_ev);
      bus.tx_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus.tx_valid_o && first_valid_ev < 0) first_valid_ev = ev;
      if (pv && !pr && (!bus.tx_valid_o || bus.tx_byte_o != pb)) viol++;
      if (bus.tx_valid_o && bus.tx_ready_i) begin
        got_q.push_back(bus.tx_byte_o);
        hs_ev_q.push_back(ev);
      end
      if (bus.done_o) begin
        done_cnt++;
        if (done_at < 0) done_at = ev;
      end
      if (ev == 1) begin addr_e1 = bus.addr_mem_debug_o; sel_e1 = bus.select_debug_o; end
      if (ev == 8) addr_e8 = bus.addr_mem_debug_o;
      pv = bus.tx_valid_o; pr = bus.tx_ready_i; pb = bus.tx_byte_o;
      if (done_at >= 0) post++;
      if (ev > 6000) begin timed_out = 1; break; end
    end
    bus.tx_ready_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start_i = 1'b1; bus.tx_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    n_cmp++; if (bus.select_debug_o !== 1'b0) begin n_bad++; $display("FAIL reset_select got=%b exp=0", bus.select_debug_o); end
    n_cmp++; if (bus.tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus.tx_valid_o); end
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
    n_cmp++; if (bus.addr_mem_debug_o !== 7'd0) begin n_bad++; $display("FAIL reset_addr got=%h exp=0", bus.addr_mem_debug_o); end
    n_cmp++; if (bus.tx_byte_o !== 8'h00) begin n_bad++; $display("FAIL reset_byte got=%h exp=00", bus.tx_byte_o); end
    bus.start_i = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got=%b exp=0", bus.busy_o); end
    n_cmp++; if (bus.tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL post_reset_valid got=%b exp=0", bus.tx_valid_o); end
  endtask

  task automatic test_first_word();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'hDEADBEEF;
    run_dump(1'b0, 0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL first_word_timeout got=1 exp=0"); end
    n_cmp++; if (first_valid_ev != 4) begin n_bad++; $display("FAIL first_valid_cycle got=%0d exp=4", first_valid_ev); end
    n_cmp++; if (addr_e1 !== 7'd0 || sel_e1 !== 1'b1) begin n_bad++; $display("FAIL addr_word0 got=%h/%b exp=0/1", addr_e1, sel_e1); end
    n_cmp++; if (addr_e8 !== 7'd1) begin n_bad++; $display("FAIL addr_word1 got=%h exp=1", addr_e8); end
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      w = 32'hDEADBEEF;
      n_cmp++;
      if (got_q.size() <= k) begin
        n_bad++; $display("FAIL first_word_byte%0d got=none exp=%h", k, w[31 - 8 * k -: 8]);
      end else if (got_q[k] !== w[31 - 8 * k -: 8] || hs_ev_q[k] != 4 + k) begin
        n_bad++; $display("FAIL first_word_byte%0d got=%h@%0d exp=%h@%0d", k, got_q[k], hs_ev_q[k], w[31 - 8 * k -: 8], 4 + k);
      end
    end
  endtask

  task automatic test_full_dump();
    int exp_done;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
    build_expected();
    exp_done = 1 + DEPTH * 7 + CHK_EXTRA;
    run_dump(1'b0, 0);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL full_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_cmp++; if (got_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL full_byte%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL full_done_count got=%0d exp=1", done_cnt); end
    n_cmp++; if (done_at != exp_done) begin n_bad++; $display("FAIL full_done_cycle got=%0d exp=%0d", done_at, exp_done); end
    n_cmp++;
    if (bus.busy_o !== 1'b0 || bus.select_debug_o !== 1'b0 || bus.addr_mem_debug_o !== 7'd0 || bus.tx_byte_o !== 8'h00) begin
      n_bad++; $display("FAIL full_idle_after got=%b/%b/%h/%h exp=0/0/00/00", bus.busy_o, bus.select_debug_o, bus.addr_mem_debug_o, bus.tx_byte_o);
    end
  endtask

  task automatic test_random_stall();
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    build_expected();
    run_dump(1'b1, 150);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL stall_timeout got=1 exp=0"); end
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_cmp++; if (got_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL stall_byte%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL stall_hold got=%0d exp=0", viol); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL stall_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int hs, cyc;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    build_expected();
    @(posedge clk); #1; bus.start_i = 1'b1; bus.tx_ready_i = 1'b1;
    @(posedge clk); #1; bus.start_i = 1'b0;
    hs = 0; cyc = 0;
    while (hs < 21 && cyc < 500) begin
      @(negedge clk);
      if (bus.tx_valid_o && bus.tx_ready_i) hs++;
      cyc++;
    end
    n_cmp++; if (hs != 21) begin n_bad++; $display("FAIL mid_reached got=%0d exp=21", hs); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy_o !== 1'b0 || bus.select_debug_o !== 1'b0 || bus.tx_valid_o !== 1'b0 || bus.tx_byte_o !== 8'h00 || bus.addr_mem_debug_o !== 7'd0) begin
      n_bad++; $display("FAIL mid_reset_outputs got=%b/%b/%b/%h/%h exp=0/0/0/00/00", bus.busy_o, bus.select_debug_o, bus.tx_valid_o, bus.tx_byte_o, bus.addr_mem_debug_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.busy_o !== 1'b0 || bus.tx_valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_release_idle got=%b/%b exp=0/0", bus.busy_o, bus.tx_valid_o); end
    run_dump(1'b0, 0);
    n_cmp++; if (got_q.size() != exp_q.size()) begin n_bad++; $display("FAIL restart_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_cmp++; if (got_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL restart_byte%0d got=%h exp=%h", k, got_q[k], exp_q[k]); end
    end
  endtask

`ifdef MEM_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    mem[0] = 32'h01020304; mem[1] = 32'h01020304;
    run_dump(1'b0, 0);
    n_cmp++;
    if (got_q.size() != 513 || got_q[got_q.size() - 1] !== 8'h00) begin
      n_bad++; $display("FAIL chksum_pair got=%0d bytes last=%h exp=513 bytes last=00", got_q.size(), got_q.size() > 0 ? got_q[got_q.size() - 1] : 8'hxx);
    end
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
    mem[0] = 32'h000000FF;
    run_dump(1'b1, 0);
    n_cmp++;
    if (got_q.size() != 513 || got_q[got_q.size() - 1] !== 8'hFF) begin
      n_bad++; $display("FAIL chksum_ff got=%0d bytes last=%h exp=513 bytes last=ff", got_q.size(), got_q.size() > 0 ? got_q[got_q.size() - 1] : 8'hxx);
    end
  endtask
`endif

  initial begin
    bus.start_i = 1'b0;
    bus.tx_ready_i = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_first_word();
    test_full_dump();
    test_random_stall();
    test_reset_mid();
`ifdef MEM_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
